digit_scanner: RTL and testbench

Time-multiplexed scan driver for a multi-digit seven-segment display. It sits directly upstream of the hex-to-segment decoder. It holds a packed multi-digit value, steps through the digits at a programmable dwell rate, and presents one 4-bit nibble at a time on A/B/C/D together with a one-hot digit enable. New values enter through a valid/ready handshake and are committed only at frame boundaries, so a displayed frame never tears.

---
 rtl/seg_pkg.sv | 11 +
 rtl/digit_scanner_if.sv | 30 +++
 rtl/digit_scanner_prescaler.sv | 32 +++
 rtl/digit_scanner.sv | 93 +++++++++
 tb/tb_digit_scanner.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/seg_pkg.sv
// Shared seven-segment definitions used by the scan driver and the hex-to-segment decoder.
// Holds the nibble type and the default display geometry.
package seg_pkg;

  localparam int NIBBLE_W         = 4;
  localparam int DEFAULT_DIGITS   = 4;
  localparam int DEFAULT_PRESCALE = 1000;

  typedef logic [NIBBLE_W-1:0] nibble_t;

endpackage

// File: rtl/digit_scanner_if.sv
// Load handshake and display-side signals of the digit scanner.
// The master side offers values; the slave side is the scanner.
interface digit_scanner_if
  import seg_pkg::*;
#(
  parameter int DIGITS = DEFAULT_DIGITS
);

  logic                         load_valid;
  logic                         load_ready;
  logic [DIGITS*NIBBLE_W-1:0]   load_data;
  logic                         lzs_en;
  logic                         A;
  logic                         B;
  logic                         C;
  logic                         D;
  logic [DIGITS-1:0]            digit_en;
  logic                         blank;

  modport master (
    output load_valid, load_data, lzs_en,
    input  load_ready, A, B, C, D, digit_en, blank
  );

  modport slave (
    input  load_valid, load_data, lzs_en,
    output load_ready, A, B, C, D, digit_en, blank
  );

endinterface

// File: rtl/digit_scanner_prescaler.sv
// Dwell prescaler for the digit scanner: counts 0..PRESCALE-1 and
// pulses tick_o for the single cycle that holds the terminal count.
module scan_prescaler
  import seg_pkg::*;
#(
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic clk,
  input  logic rst,
  output logic tick_o
);

  localparam int                PCNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PCNT_W-1:0] LAST   = PCNT_W'(PRESCALE - 1);

  logic [PCNT_W-1:0] pcnt_q;
  logic [PCNT_W-1:0] pcnt_d;

  always_comb begin
    tick_o = (pcnt_q == LAST);
    pcnt_d = tick_o ? '0 : pcnt_q + 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pcnt_q <= '0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end

endmodule

// File: rtl/digit_scanner.sv
// Time-multiplexed seven-segment scan driver: double-buffered display value,
// frame-boundary commit, and per-digit leading-zero suppression.
module digit_scanner
  import seg_pkg::*;
#(
  parameter int DIGITS   = DEFAULT_DIGITS,
  parameter int PRESCALE = DEFAULT_PRESCALE
) (
  input  logic           clk,
  input  logic           rst,
  digit_scanner_if.slave bus
);

  localparam int               IDX_W    = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int               DATA_W   = DIGITS * NIBBLE_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIGITS - 1);

  logic              tick;
  logic              frameEnd;
  logic [IDX_W-1:0]  idx_q,       idx_d;
  logic [DATA_W-1:0] disp_q,      disp_d;
  logic [DATA_W-1:0] pend_q,      pend_d;
  logic              pendValid_q, pendValid_d;

  nibble_t           curNibble;
  logic [DIGITS-1:0] curOneHot;
  logic              curZeroAbove;
  logic              allZero;
  logic              curBlank;

  scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
    .clk    (clk),
    .rst    (rst),
    .tick_o (tick)
  );

  // Commit only at end of frame so a frame never mixes old and new nibbles;
  // an accept cannot coincide with a commit because ready is low while pending.
  always_comb begin
    idx_d       = idx_q;
    disp_d      = disp_q;
    pend_d      = pend_q;
    pendValid_d = pendValid_q;
    frameEnd    = tick && (idx_q == LAST_IDX);
    if (tick) begin
      idx_d = frameEnd ? '0 : idx_q + 1'b1;
    end
    if (frameEnd && pendValid_q) begin
      disp_d      = pend_q;
      pendValid_d = 1'b0;
    end else if (bus.load_valid && !pendValid_q) begin
      pend_d      = bus.load_data;
      pendValid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx_q       <= '0;
      disp_q      <= '0;
      pend_q      <= '0;
      pendValid_q <= 1'b0;
    end else begin
      idx_q       <= idx_d;
      disp_q      <= disp_d;
      pend_q      <= pend_d;
      pendValid_q <= pendValid_d;
    end
  end

  // Walk from the top digit down so allZero means "this and every higher nibble is zero".
  always_comb begin
    curNibble    = '0;
    curOneHot    = '0;
    curZeroAbove = 1'b0;
    allZero      = 1'b1;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      allZero = allZero && (disp_q[i*NIBBLE_W +: NIBBLE_W] == '0);
      if (idx_q == IDX_W'(i)) begin
        curNibble    = disp_q[i*NIBBLE_W +: NIBBLE_W];
        curOneHot[i] = 1'b1;
        curZeroAbove = allZero;
      end
    end
    curBlank = bus.lzs_en && (idx_q != '0) && curZeroAbove;
  end

  assign bus.load_ready        = !pendValid_q;
  assign bus.blank             = curBlank;
  assign bus.digit_en          = curBlank ? '0 : curOneHot;
  assign {bus.A, bus.B, bus.C, bus.D} = curBlank ? 4'h0 : curNibble;

endmodule

// File: tb/tb_digit_scanner.sv
// Self-checking bench for digit_scanner with DIGITS=4, PRESCALE=4: table of
// display vectors plus hand-written handshake, suppression and reset sequences.
module tb_digit_scanner;
  import seg_pkg::*;

  localparam int DIGITS   = 4;
  localparam int PRESCALE = 4;

  typedef struct {
    logic [15:0] data;
    logic        lzs;
    logic [3:0]  expBlank;
    string       name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;
  vec_t vecs[7];

  always #5 clk = ~clk;

  digit_scanner_if #(.DIGITS(DIGITS)) bus ();

  digit_scanner #(.DIGITS(DIGITS), .PRESCALE(PRESCALE)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  task automatic checkOutput(string name, logic [31:0] actual, logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic checkDigit(string name, logic [3:0] expEn, logic [3:0] expNib, logic expBlank);
    checkOutput({name, " digit_en"}, 32'(bus.digit_en), 32'(expEn));
    checkOutput({name, " abcd"}, 32'({bus.A, bus.B, bus.C, bus.D}), 32'(expNib));
    checkOutput({name, " blank"}, 32'(bus.blank), 32'(expBlank));
  endtask

  // Starts on the negedge right after a frame boundary; checks every cycle of one frame.
  task automatic checkFrame(logic [15:0] data, logic [3:0] blankMask, string name, logic expReady);
    logic [3:0] expEn;
    logic [3:0] expNib;
    for (int d = 0; d < DIGITS; d++) begin
      for (int c = 0; c < PRESCALE; c++) begin
        expEn  = blankMask[d] ? 4'b0000 : 4'(1 << d);
        expNib = blankMask[d] ? 4'h0 : data[d*4 +: 4];
        checkDigit($sformatf("%s d%0d c%0d", name, d, c), expEn, expNib, blankMask[d]);
        if (d != 0 || c != 0) begin
          checkOutput($sformatf("%s ready d%0d c%0d", name, d, c), 32'(bus.load_ready), 32'(expReady));
        end
        @(negedge clk);
      end
    end
  endtask

  task automatic waitReady(string name);
    for (int n = 0; n < 40 && !bus.load_ready; n++) @(negedge clk);
    checkOutput(name, 32'(bus.load_ready), 32'd1);
  endtask

  // Offers a value, waits for accept, then waits for the commit edge.
  task automatic applyStimulus(logic [15:0] data);
    bus.load_data  = data;
    bus.load_valid = 1'b1;
    waitReady("accept wait");
    @(negedge clk);
    bus.load_valid = 1'b0;
    checkOutput("ready low after accept", 32'(bus.load_ready), 32'd0);
    waitReady("commit wait");
  endtask

  initial begin
    vecs[0] = '{16'h1234, 1'b0, 4'b0000, "plain 1234"};
    vecs[1] = '{16'h0070, 1'b1, 4'b1100, "lzs 0070"};
    vecs[2] = '{16'h0000, 1'b1, 4'b1110, "lzs 0000"};
    vecs[3] = '{16'h0070, 1'b0, 4'b0000, "nolzs 0070"};
    vecs[4] = '{16'hB0E0, 1'b1, 4'b0000, "lzs B0E0"};
    vecs[5] = '{16'h0105, 1'b1, 4'b1000, "lzs 0105"};
    vecs[6] = '{16'hFFFF, 1'b1, 4'b0000, "lzs FFFF"};

    rst            = 1'b1;
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.lzs_en     = 1'b0;
    repeat (2) @(negedge clk);
    checkDigit("reset", 4'b0001, 4'h0, 1'b0);
    checkOutput("reset ready", 32'(bus.load_ready), 32'd1);

    // First digit change lands exactly PRESCALE cycles after release.
    rst = 1'b0;
    for (int c = 1; c < PRESCALE; c++) begin
      @(negedge clk);
      checkOutput($sformatf("post-reset hold c%0d", c), 32'(bus.digit_en), 32'b0001);
    end
    @(negedge clk);
    checkOutput("post-reset first step", 32'(bus.digit_en), 32'b0010);

    for (int v = 0; v < 7; v++) begin
      bus.lzs_en = vecs[v].lzs;
      applyStimulus(vecs[v].data);
      checkFrame(vecs[v].data, vecs[v].expBlank, vecs[v].name, 1'b1);
    end

    // Accept one cycle before the end-of-frame tick: commits on the very next edge.
    bus.lzs_en = 1'b0;
    repeat (14) @(negedge clk);
    bus.load_data  = 16'h1234;
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    checkOutput("late accept ready", 32'(bus.load_ready), 32'd0);
    checkDigit("late accept old", 4'b1000, 4'hF, 1'b0);
    @(negedge clk);
    checkOutput("late accept commit ready", 32'(bus.load_ready), 32'd1);
    checkDigit("late accept new", 4'b0001, 4'h4, 1'b0);

    // Accept on the end-of-frame tick itself: held until the following frame end.
    repeat (15) @(negedge clk);
    bus.load_data  = 16'h5678;
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    checkOutput("eof accept ready", 32'(bus.load_ready), 32'd0);
    checkFrame(16'h1234, 4'b0000, "eof accept old", 1'b0);
    checkOutput("eof accept commit ready", 32'(bus.load_ready), 32'd1);
    checkFrame(16'h5678, 4'b0000, "eof accept new", 1'b1);

    // Back-to-back: 0x5555 held valid behind 0xAAAA.
    bus.load_data  = 16'hAAAA;
    bus.load_valid = 1'b1;
    waitReady("b2b accept wait");
    @(negedge clk);
    bus.load_data = 16'h5555;
    waitReady("b2b commit wait");
    checkFrame(16'hAAAA, 4'b0000, "b2b A", 1'b0);
    bus.load_valid = 1'b0;
    checkOutput("b2b second commit ready", 32'(bus.load_ready), 32'd1);
    checkFrame(16'h5555, 4'b0000, "b2b 5", 1'b1);

    // lzs_en toggled mid-dwell on digit 3 of 0x0070.
    bus.lzs_en = 1'b1;
    applyStimulus(16'h0070);
    repeat (13) @(negedge clk);
    checkDigit("toggle before", 4'b0000, 4'h0, 1'b1);
    bus.lzs_en = 1'b0;
    #1;
    checkDigit("toggle after", 4'b1000, 4'h0, 1'b0);
    @(negedge clk);
    checkDigit("toggle hold c2", 4'b1000, 4'h0, 1'b0);
    @(negedge clk);
    checkDigit("toggle hold c3", 4'b1000, 4'h0, 1'b0);
    @(negedge clk);
    checkDigit("toggle wrap", 4'b0001, 4'h0, 1'b0);
    repeat (4) @(negedge clk);
    checkDigit("toggle digit1", 4'b0010, 4'h7, 1'b0);

    // Reset mid-frame with a pending value: everything cleared, pending value lost.
    applyStimulus(16'hBEEF);
    repeat (9) @(negedge clk);
    checkDigit("beef digit2", 4'b0100, 4'hE, 1'b0);
    bus.load_data  = 16'h1111;
    bus.load_valid = 1'b1;
    @(negedge clk);
    bus.load_valid = 1'b0;
    checkOutput("pending 1111 ready", 32'(bus.load_ready), 32'd0);
    #2 rst = 1'b1;
    #1;
    checkDigit("async reset", 4'b0001, 4'h0, 1'b0);
    checkOutput("async reset ready", 32'(bus.load_ready), 32'd1);
    @(negedge clk);
    rst = 1'b0;
    checkFrame(16'h0000, 4'b0000, "after reset f1", 1'b1);
    checkFrame(16'h0000, 4'b0000, "after reset f2", 1'b1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
